// File: rtl/pipe_stage_skid_pkg.sv
// Shared defines for the pipeline-stage slice: word/register widths and control-flag bit positions.
package pipe_stage_skid_pkg;

    localparam int unsigned WORD_LEN          = 32;
    localparam int unsigned REG_FILE_ADDR_LEN = 5;
    localparam int unsigned NUM_PAY_WORDS     = 3;
    localparam int unsigned FLAG_CNT          = 4;

    localparam int unsigned FLAG_WB_EN    = 0;
    localparam int unsigned FLAG_MEM_R_EN = 1;
    localparam int unsigned FLAG_MUL_EN   = 2;
    localparam int unsigned FLAG_COMP_EN  = 3;

endpackage

// File: rtl/stage_entry_reg.sv
// One pipeline entry (flags, destination, payload) with load enable and async active-low clear.
module stage_entry_reg #(
    parameter int unsigned FLAG_W = 4,
    parameter int unsigned DEST_W = 5,
    parameter int unsigned PAY_W  = 96
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [FLAG_W-1:0] flags_i,
    input  logic [DEST_W-1:0] dest_i,
    input  logic [PAY_W-1:0]  data_i,
    output logic [FLAG_W-1:0] flags_o,
    output logic [DEST_W-1:0] dest_o,
    output logic [PAY_W-1:0]  data_o
);

    logic [FLAG_W-1:0] flags_q;
    logic [DEST_W-1:0] dest_q;
    logic [PAY_W-1:0]  data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
            dest_q  <= '0;
            data_q  <= '0;
        end else if (load_i) begin
            flags_q <= flags_i;
            dest_q  <= dest_i;
            data_q  <= data_i;
        end
    end

    assign flags_o = flags_q;
    assign dest_o  = dest_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffered pipeline stage: main register drives the outputs, skid register
// absorbs one extra entry so in_ready depends only on state and flush.
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int unsigned DATA_W  = WORD_LEN,
    parameter int unsigned NUM_PAY = NUM_PAY_WORDS,
    parameter int unsigned DEST_W  = REG_FILE_ADDR_LEN,
    parameter int unsigned FLAG_W  = FLAG_CNT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [FLAG_W-1:0]         in_flags,
    input  logic [DEST_W-1:0]         in_dest,
    input  logic [NUM_PAY*DATA_W-1:0] in_data,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [FLAG_W-1:0]         out_flags,
    output logic [DEST_W-1:0]         out_dest,
    output logic [NUM_PAY*DATA_W-1:0] out_data,
    output logic [1:0]                occupancy
);

    localparam int unsigned PAY_W = NUM_PAY * DATA_W;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic push, pop;
    logic main_load, skid_load, main_from_skid;

    logic [FLAG_W-1:0] main_flags_d, main_flags_q, skid_flags_q;
    logic [DEST_W-1:0] main_dest_d,  main_dest_q,  skid_dest_q;
    logic [PAY_W-1:0]  main_data_d,  main_data_q,  skid_data_q;

    assign in_ready  = (state_q != S_FULL) & ~flush;
    assign out_valid = (state_q != S_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // flush only forces EMPTY; stale register contents are hidden by out_valid gating out_flags
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (push) begin
                        state_d   = S_ONE;
                        main_load = 1'b1;
                    end
                end
                S_ONE: begin
                    if (push && pop) begin
                        main_load = 1'b1;
                    end else if (push) begin
                        state_d   = S_FULL;
                        skid_load = 1'b1;
                    end else if (pop) begin
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (pop) begin
                        state_d        = S_ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_comb begin
        occupancy = 2'd0;
        unique case (state_q)
            S_EMPTY: occupancy = 2'd0;
            S_ONE:   occupancy = 2'd1;
            S_FULL:  occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    assign main_flags_d = main_from_skid ? skid_flags_q : in_flags;
    assign main_dest_d  = main_from_skid ? skid_dest_q  : in_dest;
    assign main_data_d  = main_from_skid ? skid_data_q  : in_data;

    stage_entry_reg #(
        .FLAG_W (FLAG_W),
        .DEST_W (DEST_W),
        .PAY_W  (PAY_W)
    ) u_main (
        .clk     (clk),
        .rst_n   (rst),
        .load_i  (main_load),
        .flags_i (main_flags_d),
        .dest_i  (main_dest_d),
        .data_i  (main_data_d),
        .flags_o (main_flags_q),
        .dest_o  (main_dest_q),
        .data_o  (main_data_q)
    );

    stage_entry_reg #(
        .FLAG_W (FLAG_W),
        .DEST_W (DEST_W),
        .PAY_W  (PAY_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst),
        .load_i  (skid_load),
        .flags_i (in_flags),
        .dest_i  (in_dest),
        .data_i  (in_data),
        .flags_o (skid_flags_q),
        .dest_o  (skid_dest_q),
        .data_o  (skid_data_q)
    );

    assign out_flags = out_valid ? main_flags_q : '0;
    assign out_dest  = main_dest_q;
    assign out_data  = main_data_q;

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DATA_W, default 32, width of one payload word (equals WORD_LEN).
REQ-002 Parameter NUM_PAY, default 3, number of payload words per entry (result, memory read value, HIGH).
REQ-003 Parameter DEST_W, default 5, destination register address width (equals REG_FILE_ADDR_LEN).
REQ-004 Parameter FLAG_W, default 4, control-flag width (WB_EN, MEM_R_EN, MUL_EN, COMP_EN, bit 0 upward).
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 in_valid  in  1  upstream entry present.
REQ-008 in_ready  out  1  stage can accept an entry this cycle.
REQ-009 in_flags  in  FLAG_W  upstream control flags.
REQ-010 in_dest  in  DEST_W  upstream destination register.
REQ-011 in_data  in  NUM_PAY*DATA_W  packed payload words; word k at bits [k*DATA_W +: DATA_W].
REQ-012 flush  in  1  synchronous kill of all held entries.
REQ-013 out_valid  out  1  output entry present.
REQ-014 out_ready  in  1  downstream accepts the output entry.
REQ-015 out_flags  out  FLAG_W  output flags, forced 0 when out_valid=0.
REQ-016 out_dest  out  DEST_W  output destination register.
REQ-017 out_data  out  NUM_PAY*DATA_W  output payload.
REQ-018 occupancy  out  2  entries held (0, 1 or 2).

Function
REQ-019 Push = in_valid & in_ready; pop = out_valid & out_ready; both evaluated each cycle.
REQ-020 Storage: main register (drives outputs) plus one skid register; each holds flags, dest, data.
REQ-021 State machine EMPTY/ONE/FULL; occupancy = 0/1/2; out_valid = (state != EMPTY).
REQ-022 in_ready = (state != FULL) & ~flush; depends on no other input.
REQ-023 EMPTY: push -> ONE, main <= input; otherwise stay EMPTY.
REQ-024 ONE: push & pop -> ONE, main <= input; push only -> FULL, skid <= input; pop only -> EMPTY; neither -> hold.
REQ-025 FULL: pop -> ONE, main <= skid; no pop -> hold both registers unchanged.
REQ-026 Latency: an entry pushed into EMPTY appears on out_* the next cycle; throughput is one entry per cycle while out_ready=1.
REQ-027 Order is strictly FIFO; no entry is duplicated or dropped except by flush.
REQ-028 flush takes priority over push and pop: next state EMPTY, any same-cycle input is discarded, and register contents are don't-care except that out_flags reads 0.
REQ-029 While out_valid=1 and out_ready=0, out_flags, out_dest and out_data stay stable.
REQ-030 When out_valid=0, out_dest and out_data hold their last value and out_flags=0, so WB_EN never asserts on a bubble.

Reset
REQ-031 While rst=0: state EMPTY, occupancy 0, out_valid 0, out_flags 0, out_dest 0, out_data 0, skid register 0.
REQ-032 Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
REQ-033 in_ready returns 1 on the first cycle after rst deasserts (flush=0).

Structure
REQ-034 WORD_LEN, REG_FILE_ADDR_LEN and the flag bit indices (FLAG_WB_EN=0, FLAG_MEM_R_EN=1, FLAG_MUL_EN=2, FLAG_COMP_EN=3) SHALL live in the shared defines package.
REQ-035 State encoding SHALL be a local constant set inside the module.
REQ-036 One sub-module, stage_entry_reg, SHALL hold one entry (flags, dest, data) with a load enable and async active-low clear; it is instantiated twice.

Verification
REQ-037 Reset during FULL -> out_valid=0, occupancy=0 and out_flags=0 immediately; in_ready=1 after release.
REQ-038 Streaming 8 entries (data=k, dest=k) with out_ready=1 -> out_* shows k one cycle after push; in_ready stays 1.
REQ-039 Push A, B with out_ready=0 -> occupancy=2, in_ready=0, out shows A stable; raise out_ready -> A, then B, in order.
REQ-040 FULL, with flush and in_valid (entry C) in the same cycle -> EMPTY next cycle, C never appears, out_flags=0.
REQ-041 ONE with push and pop in the same cycle -> occupancy stays 1 and the new entry is on out_* next cycle.
REQ-042 NUM_PAY=1, DATA_W=64 build -> the REQ-038 stream passes with 64-bit data=0xFFFF_0000_FFFF_0001.
